// File: rtl/dm_ctrl_pkg.sv
// Shared encodings for the data-memory controller: access types and FSM states.
// The DM_* codes are also used by the main decoder when it builds req_type.
package dm_ctrl_pkg;

  localparam logic [2:0] DM_WORD  = 3'd0;
  localparam logic [2:0] DM_HALF  = 3'd1;
  localparam logic [2:0] DM_HALFU = 3'd2;
  localparam logic [2:0] DM_BYTE  = 3'd3;
  localparam logic [2:0] DM_BYTEU = 3'd4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

endpackage

// File: rtl/dm_ctrl_if.sv
// Word-wide data-memory port with a req/ack handshake and variable wait states.
// The controller is the master; the memory (or bus bridge) is the slave.
interface dm_ctrl_if #(
  parameter int AW = 32
);

  logic          mem_req;
  logic          mem_we;
  logic [AW-3:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/dm_lane.sv
// Combinational byte-lane unit: store byte enables and lane replication,
// load lane selection with sign/zero extension, and misalignment detection.
module dm_lane
  import dm_ctrl_pkg::*;
(
  input  logic [2:0]  dm_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [15:0] half_v;
  logic [7:0]  byte_v;

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case leaves a latch.
    be        = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = rdata;
    misalign  = |addr_lo;
    half_v    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    byte_v    = rdata[{addr_lo, 3'b000} +: 8];

    // Undefined codes fall through to the word behaviour set above.
    case (dm_type)
      DM_HALF, DM_HALFU: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        misalign  = addr_lo[0];
        rdata_ext = (dm_type == DM_HALF) ? {{16{half_v[15]}}, half_v}
                                         : {16'h0000, half_v};
      end
      DM_BYTE, DM_BYTEU: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        misalign  = 1'b0;
        rdata_ext = (dm_type == DM_BYTE) ? {{24{byte_v[7]}}, byte_v}
                                         : {24'h000000, byte_v};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_ctrl.sv
// Memory-stage load/store controller: issues one word access per instruction
// over a req/ack port, stalls the pipeline until it completes, and extends loads.
module dm_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [2:0]    req_type,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          stall,
  output logic          done,
  output logic          misalign,
  output logic [31:0]   rd_data,
  dm_ctrl_if.master     mem
);

  logic [1:0]    state;
  logic [2:0]    type_q;
  logic [1:0]    addr_lo_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [AW-3:0] mem_addr_q;
  logic [3:0]    mem_be_q;
  logic [31:0]   mem_wdata_q;
  logic          misalign_q;
  logic [31:0]   rd_data_q;

  logic [2:0]    lane_type;
  logic [1:0]    lane_addr;
  logic [3:0]    lane_be;
  logic [31:0]   lane_wdata;
  logic [31:0]   lane_rdata;
  logic          lane_misalign;

  // In IDLE the lane unit decodes the live request; afterwards it extends
  // the returning word using the type and offset latched at issue.
  assign lane_type = (state == S_IDLE) ? req_type       : type_q;
  assign lane_addr = (state == S_IDLE) ? req_addr[1:0]  : addr_lo_q;

  dm_lane u_lane (
    .dm_type   (lane_type),
    .addr_lo   (lane_addr),
    .wdata     (req_wdata),
    .rdata     (mem.mem_rdata),
    .be        (lane_be),
    .wdata_rep (lane_wdata),
    .rdata_ext (lane_rdata),
    .misalign  (lane_misalign)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register see pre-edge values, independent of statement order.
    if (rst) begin
      state       <= S_IDLE;
      type_q      <= DM_WORD;
      addr_lo_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      misalign_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (lane_misalign) begin
              misalign_q <= 1'b1;
              state      <= S_DONE;
            end else begin
              type_q      <= req_type;
              addr_lo_q   <= req_addr[1:0];
              mem_addr_q  <= req_addr[AW-1:2];
              mem_we_q    <= req_we;
              mem_be_q    <= req_we ? lane_be : 4'b1111;
              mem_wdata_q <= lane_wdata;
              mem_req_q   <= 1'b1;
              state       <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (mem.mem_ack) begin
            mem_req_q <= 1'b0;
            if (!mem_we_q) rd_data_q <= lane_rdata;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          // The CPU still presents the finished instruction here, so req_valid is ignored.
          misalign_q <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign stall    = ((state == S_IDLE) && req_valid) || (state == S_ACCESS);
  assign done     = (state == S_DONE);
  assign misalign = done && misalign_q;
  assign rd_data  = rd_data_q;

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_be    = mem_be_q;
  assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Scoreboard bench for dm_ctrl: directed loads/stores against a wait-state memory
// model; a negedge monitor checks every memory request and every done pulse.
module tb_dm_ctrl;
  import dm_ctrl_pkg::*;

  localparam int AW = 32;

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_wdata;
    int          cyc;
  } mem_exp_t;

  typedef struct {
    string       name;
    logic        mis;
    logic [31:0] rd;
    logic        chk_rd;
    int          cyc;
  } done_exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [2:0]    req_type = DM_WORD;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          stall;
  logic          done;
  logic          misalign;
  logic [31:0]   rd_data;

  logic          ack_auto = 1'b0;
  logic          late_ack = 1'b0;
  logic [31:0]   rdata_word = '0;
  int            wait_states = 0;
  int            wcnt = 0;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int done_count = 0;
  int req_count = 0;

  mem_exp_t  mem_q[$];
  done_exp_t done_q[$];
  mem_exp_t  cur_mem;
  logic      have_mem = 1'b0;
  logic      prev_req = 1'b0;

  dm_ctrl_if #(.AW(AW)) mem ();

  assign mem.mem_ack   = ack_auto | late_ack;
  assign mem.mem_rdata = rdata_word;

  dm_ctrl #(.AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_type  (req_type),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .stall     (stall),
    .done      (done),
    .misalign  (misalign),
    .rd_data   (rd_data),
    .mem       (mem)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic report_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Memory model: acks after wait_states idle request cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ack_auto = 1'b0;
      if (mem.mem_req) begin
        if (wcnt == wait_states) begin
          ack_auto = 1'b1;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT starts a request or pulses done.
  always @(negedge clk) begin
    if (mem.mem_req) begin
      if (!prev_req) begin
        req_count++;
        if (mem_q.size() == 0) begin
          have_mem = 1'b0;
          report_fail("unexpected mem_req");
        end else begin
          cur_mem  = mem_q.pop_front();
          have_mem = 1'b1;
          check("mem_req_cycle", 32'(cyc), 32'(cur_mem.cyc));
        end
      end
      if (have_mem) begin
        check("mem_we", 32'(mem.mem_we), 32'(cur_mem.we));
        check("mem_addr", 32'(mem.mem_addr), 32'(cur_mem.addr));
        check("mem_be", 32'(mem.mem_be), 32'(cur_mem.be));
        if (cur_mem.chk_wdata) check("mem_wdata", mem.mem_wdata, cur_mem.wdata);
      end
    end
    prev_req = mem.mem_req;

    if (done) begin
      done_count++;
      if (done_q.size() == 0) begin
        report_fail("unexpected done");
      end else begin
        done_exp_t e;
        e = done_q.pop_front();
        check({e.name, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
        check({e.name, "_misalign"}, 32'(misalign), 32'(e.mis));
        if (e.chk_rd) check({e.name, "_rd_data"}, rd_data, e.rd);
      end
    end else if (misalign) begin
      report_fail("misalign without done");
    end
  end

  task automatic check_reset_values(input string tag);
    @(negedge clk);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_misalign"}, 32'(misalign), 32'd0);
    check({tag, "_rd_data"}, rd_data, 32'd0);
    check({tag, "_mem_req"}, 32'(mem.mem_req), 32'd0);
    check({tag, "_mem_we"}, 32'(mem.mem_we), 32'd0);
    check({tag, "_mem_be"}, 32'(mem.mem_be), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem.mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, mem.mem_wdata, 32'd0);
  endtask

  task automatic do_access(
    input string       name,
    input logic        we,
    input logic [2:0]  typ,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [31:0] word,
    input int          waits,
    input logic        exp_mis,
    input logic [3:0]  exp_be,
    input logic [31:0] exp_wdata,
    input logic [31:0] exp_rd,
    input logic        chk_rd,
    input logic        hold
  );
    int start;
    int budget;
    wait_states = waits;
    rdata_word  = word;
    @(posedge clk);
    #1;
    start = done_count;
    if (!exp_mis)
      mem_q.push_back('{we: we, addr: addr[31:2], be: exp_be, wdata: exp_wdata,
                        chk_wdata: we, cyc: cyc + 1});
    done_q.push_back('{name: name, mis: exp_mis, rd: exp_rd, chk_rd: chk_rd,
                       cyc: cyc + (exp_mis ? 1 : 2 + waits)});
    req_valid = 1'b1;
    req_we    = we;
    req_type  = typ;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    #1;
    check({name, "_stall_issue"}, 32'(stall), 32'd1);
    if (!hold) begin
      @(posedge clk);
      #1;
      req_valid = 1'b0;
    end
    budget = 40;
    do begin
      @(negedge clk);
      #1;
      budget--;
      check({name, "_stall"}, 32'(stall), (done_count == start) ? 32'd1 : 32'd0);
    end while (done_count == start && budget > 0);
    if (done_count == start) report_fail({name, "_done_timeout"});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int r0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_values("reset");

    //        name    we    type      addr          wdata         mem word      w  mis   be       wdata         rd            chk hold
    do_access("lw",   1'b0, DM_WORD,  32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 4'b1111, 32'h0,        32'hDEAD_BEEF, 1, 0);
    do_access("lb",   1'b0, DM_BYTE,  32'h0000_0013, 32'h0,        32'h80FF_7F01, 0, 1'b0, 4'b1111, 32'h0,        32'hFFFF_FF80, 1, 0);
    do_access("lbu",  1'b0, DM_BYTEU, 32'h0000_0013, 32'h0,        32'h80FF_7F01, 0, 1'b0, 4'b1111, 32'h0,        32'h0000_0080, 1, 0);
    do_access("sh",   1'b1, DM_HALF,  32'h0000_0022, 32'h1234_ABCD, 32'h0,        3, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0000_0080, 1, 0);
    do_access("lh",   1'b0, DM_HALF,  32'h0000_0022, 32'h0,        32'h8001_1234, 1, 1'b0, 4'b1111, 32'h0,        32'hFFFF_8001, 1, 0);
    do_access("lhu",  1'b0, DM_HALFU, 32'h0000_0020, 32'h0,        32'h8001_1234, 0, 1'b0, 4'b1111, 32'h0,        32'h0000_1234, 1, 0);
    do_access("lb1",  1'b0, DM_BYTE,  32'h0000_0011, 32'h0,        32'h80FF_7F01, 2, 1'b0, 4'b1111, 32'h0,        32'h0000_007F, 1, 0);
    do_access("lundef",1'b0, 3'b111,  32'h0000_000C, 32'h0,        32'h7654_3210, 0, 1'b0, 4'b1111, 32'h0,        32'h7654_3210, 1, 0);
    do_access("sw",   1'b1, DM_WORD,  32'h0000_0030, 32'hCAFE_F00D, 32'h0,        1, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h7654_3210, 1, 0);
    do_access("lw_mis",1'b0, DM_WORD, 32'h0000_0006, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,        0, 0);
    do_access("sh_mis",1'b1, DM_HALF, 32'h0000_0005, 32'h1111_2222, 32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,        0, 0);
    do_access("sb",   1'b1, DM_BYTE,  32'h0000_0007, 32'h1122_335A, 32'h0,        0, 1'b0, 4'b1000, 32'h5A5A_5A5A, 32'h7654_3210, 1, 0);

    // Reset in the second ACCESS cycle; a later ack must not produce done.
    wait_states = 20;
    d0 = done_count;
    @(posedge clk);
    #1;
    mem_q.push_back('{we: 1'b0, addr: 30'h10, be: 4'b1111, wdata: 32'h0, chk_wdata: 1'b0, cyc: cyc + 1});
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_type  = DM_WORD;
    req_addr  = 32'h0000_0040;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_values("rst_access");
    @(posedge clk);
    #1;
    late_ack = 1'b1;
    @(posedge clk);
    #1;
    late_ack = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("rst_no_done", 32'(done_count), 32'(d0));

    // req_valid held through DONE: exactly one access and one done pulse.
    d0 = done_count;
    r0 = req_count;
    do_access("hold", 1'b0, DM_WORD, 32'h0000_0010, 32'h0, 32'h0BAD_F00D, 1, 1'b0, 4'b1111, 32'h0, 32'h0BAD_F00D, 1, 1);
    repeat (5) @(negedge clk);
    #1;
    check("hold_done_count", 32'(done_count - d0), 32'd1);
    check("hold_req_count", 32'(req_count - r0), 32'd1);

    check("mem_q_drained", 32'(mem_q.size()), 32'd0);
    check("done_q_drained", 32'(done_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
